quiz_host_ctrl: RTL
===================

// Module: quiz_host_ctrl
// PURPOSE
// Host-side controller for the quiz buzzer responder. Arms a round: clears the responder and
// runs a BCD seconds countdown for the buzz window. Consumes the responder's stoptimer/result
// pair and runs a per-winner answer window. Applies the host's right/wrong judgement to
// per-player BCD scores, and drives time and score values to the display logic.
// PARAMETERS
// TICKS_PER_SEC  50_000_000  clk cycles per countdown second (bench uses 4)
// BUZZ_SEC       10          buzz-window length in seconds, 1..99
// ANSWER_SEC     20          answer-window length in seconds, 1..99
// PORTS
// clk               in   1  system clock
// rst               in   1  asynchronous active-low reset
// start             in   1  one-cycle host pulse: begin a round
// judge_ok          in   1  one-cycle pulse: answer correct
// judge_bad         in   1  one-cycle pulse: answer wrong
// clear_scores      in   1  one-cycle pulse: zero all scores
// number_of_player  in   4  active players, BCD, range 2..4
// stoptimer         in   1  from responder: a valid buzz has been latched
// result            in   4  from responder: winning player 1..4
// showready         out  1  to responder: hold result cleared
// resp_clr_n        out  1  to responder reset: active-low one-cycle clear
// time_bcd          out  8  remaining seconds as two BCD digits {tens,ones}
// winner            out  4  latched winning player (0 = none)
// score1..score4    out  4  per-player score, one BCD digit, 0..9
// state_o           out  3  current FSM state code
// timeout           out  1  high while in TIMEOUT state
// beep              out  1  one-cycle pulse on buzz accept and on any window expiry
// BEHAVIOUR
// - Reset (async, rst=0) sets:
//   - state=IDLE, showready=1, resp_clr_n=1, time_bcd=BCD(BUZZ_SEC)
//   - winner=0, all scores=0, timeout=0, beep=0, prescaler=0
// - States: IDLE=0, ARM=1, BUZZ=2, ANSWER=3, DONE=4, TIMEOUT=5.
// - IDLE/DONE/TIMEOUT:
//   - showready=1.
//   - start goes to ARM on the next edge.
//   - clear_scores zeroes the scores. It is ignored in ARM, BUZZ and ANSWER.
// - ARM lasts exactly 1 cycle:
//   - resp_clr_n=0, showready=0, winner=0, timeout=0.
//   - time_bcd is loaded with BCD(BUZZ_SEC) and the prescaler is cleared. Next state is BUZZ.
// - BUZZ:
//   - Prescaler counts 0..TICKS_PER_SEC-1. At wrap, time_bcd decrements by one BCD second
//     (x0 -> (x-1)9).
//   - The first decrement occurs TICKS_PER_SEC cycles after entry.
//   - stoptimer=1 with 1<=result<=number_of_player: latch winner=result, pulse beep, go to
//     ANSWER. time_bcd reloads with BCD(ANSWER_SEC) and the prescaler clears.
//   - stoptimer=1 with result out of range: ignored, and BUZZ continues.
//   - A valid buzz on the same cycle as the decrement to 00 wins; the round goes to ANSWER.
//   - time_bcd reaching 00 with no buzz: go to TIMEOUT and pulse beep.
// - ANSWER:
//   - Countdown runs with the same rules as BUZZ. stoptimer is ignored.
//   - judge_ok alone: score[winner] += 1, saturating at 9. Go to DONE.
//   - judge_bad alone: score[winner] -= 1, saturating at 0. Go to DONE.
//   - judge_ok and judge_bad together: ignored.
//   - Expiry to 00: no score change. Pulse beep, go to DONE.
//   - A judge pulse on the expiry cycle takes priority over the expiry.
// - time_bcd freezes in DONE and TIMEOUT. winner holds until the next ARM.
// - start while in ARM/BUZZ/ANSWER is ignored. A round is only restarted by reset.
// - number_of_player outside 2..4 is treated as 4.
// - Mid-operation reset: immediate return to the reset values, and scores are lost.
// - All outputs are registered. beep is high for exactly 1 cycle per event.
// TESTING
// - TICKS=4, BUZZ=3:
//   - start, then after 2 ticks stoptimer=1, result=2, players=4.
//   - Expect resp_clr_n low for 1 cycle; winner=2, beep pulse, time_bcd=ANSWER_SEC,
//     state=ANSWER.
// - No buzz: time_bcd 03->02->01->00 at 4-cycle steps, then TIMEOUT, timeout=1,
//   a single beep, scores unchanged.
// - players=3, stoptimer=1, result=4: ignored, and BUZZ continues.
//   A following result=3 makes winner=3.
// - Score saturation:
//   - winner=1, ten rounds of judge_ok: score1 saturates at 9.
//   - judge_bad with score1=0: score1 stays 0.
//   - judge_ok and judge_bad on the same cycle: no change, state stays ANSWER.
// - Answer expiry: state goes to DONE with no score change. Then clear_scores: all scores 0.
//   - clear_scores during BUZZ: ignored.
// - Reset mid-ANSWER with score2=5: every output returns to its reset value next cycle, and
//   score2=0.

Source files
------------

// File: rtl/quiz_host_ctrl_if.sv
// rtl/quiz_host_ctrl_if.sv - responder handshake between quiz host controller and buzzer responder
interface quiz_host_ctrl_if;
    logic       stoptimer;
    logic [3:0] result;
    logic       showready;
    logic       resp_clr_n;

    modport master (
        input  stoptimer,
        input  result,
        output showready,
        output resp_clr_n
    );

    modport slave (
        output stoptimer,
        output result,
        input  showready,
        input  resp_clr_n
    );
endinterface

// File: rtl/quiz_host_ctrl.sv
// rtl/quiz_host_ctrl.sv - quiz host controller: round arming, BCD countdowns, winner latch, BCD scores
module quiz_host_ctrl #(
    parameter int TICKS_PER_SEC = 50_000_000,
    parameter int BUZZ_SEC      = 10,
    parameter int ANSWER_SEC    = 20
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    start_i,
    input  logic                    judge_ok_i,
    input  logic                    judge_bad_i,
    input  logic                    clear_scores_i,
    input  logic [3:0]              number_of_player_i,
    quiz_host_ctrl_if.master        resp,
    output logic [7:0]              time_bcd_o,
    output logic [3:0]              winner_o,
    output logic [3:0]              score1_o,
    output logic [3:0]              score2_o,
    output logic [3:0]              score3_o,
    output logic [3:0]              score4_o,
    output logic [2:0]              state_o,
    output logic                    timeout_o,
    output logic                    beep_o
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARM     = 3'd1,
        S_BUZZ    = 3'd2,
        S_ANSWER  = 3'd3,
        S_DONE    = 3'd4,
        S_TIMEOUT = 3'd5
    } state_e;

    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);
    localparam logic [3:0] BUZZ_T   = 4'(BUZZ_SEC / 10);
    localparam logic [3:0] BUZZ_O   = 4'(BUZZ_SEC % 10);
    localparam logic [3:0] ANS_T    = 4'(ANSWER_SEC / 10);
    localparam logic [3:0] ANS_O    = 4'(ANSWER_SEC % 10);
    localparam logic [7:0] BUZZ_BCD = {BUZZ_T, BUZZ_O};
    localparam logic [7:0] ANS_BCD  = {ANS_T, ANS_O};

    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        if (v[3:0] == 4'd0) begin
            return {v[7:4] - 4'd1, 4'd9};
        end
        return {v[7:4], v[3:0] - 4'd1};
    endfunction

    state_e        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [7:0]    time_q, time_d;
    logic [3:0]    winner_q, winner_d;
    logic [3:0]    score_q [4];
    logic [3:0]    score_d [4];
    logic          showready_q, showready_d;
    logic          clr_n_q, clr_n_d;
    logic          timeout_q, timeout_d;
    logic          beep_q, beep_d;

    logic [3:0]    player_limit;
    logic          buzz_valid;
    logic          judge_one;
    logic          tick;
    logic [7:0]    time_next;
    logic          expire;

    // Out-of-range player counts fall back to the full four-player game.
    assign player_limit = (number_of_player_i >= 4'd2 && number_of_player_i <= 4'd4)
                        ? number_of_player_i : 4'd4;
    assign buzz_valid   = resp.stoptimer && (resp.result != 4'd0) && (resp.result <= player_limit);
    assign judge_one    = judge_ok_i ^ judge_bad_i;
    assign tick         = (presc_q == PRESC_LAST);
    assign time_next    = bcd_dec(time_q);
    assign expire       = tick && (time_next == 8'h00);

    always_comb begin
        state_d  = state_q;
        presc_d  = presc_q;
        time_d   = time_q;
        winner_d = winner_q;
        beep_d   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            score_d[i] = score_q[i];
        end

        case (state_q)
            S_IDLE, S_DONE, S_TIMEOUT: begin
                if (clear_scores_i) begin
                    for (int i = 0; i < 4; i++) begin
                        score_d[i] = 4'd0;
                    end
                end
                if (start_i) begin
                    state_d  = S_ARM;
                    winner_d = 4'd0;
                    time_d   = BUZZ_BCD;
                    presc_d  = '0;
                end
            end
            S_ARM: begin
                state_d = S_BUZZ;
                time_d  = BUZZ_BCD;
                presc_d = '0;
            end
            S_BUZZ: begin
                // A valid buzz outranks the countdown, including its final step to 00.
                if (buzz_valid) begin
                    state_d  = S_ANSWER;
                    winner_d = resp.result;
                    time_d   = ANS_BCD;
                    presc_d  = '0;
                    beep_d   = 1'b1;
                end else begin
                    presc_d = tick ? '0 : presc_q + 1'b1;
                    if (tick) begin
                        time_d = time_next;
                    end
                    if (expire) begin
                        state_d = S_TIMEOUT;
                        beep_d  = 1'b1;
                    end
                end
            end
            S_ANSWER: begin
                if (judge_one) begin
                    for (int i = 0; i < 4; i++) begin
                        if (winner_q == 4'(i + 1)) begin
                            if (judge_ok_i) begin
                                score_d[i] = (score_q[i] >= 4'd9) ? 4'd9 : score_q[i] + 4'd1;
                            end else begin
                                score_d[i] = (score_q[i] == 4'd0) ? 4'd0 : score_q[i] - 4'd1;
                            end
                        end
                    end
                    state_d = S_DONE;
                end else begin
                    presc_d = tick ? '0 : presc_q + 1'b1;
                    if (tick) begin
                        time_d = time_next;
                    end
                    if (expire) begin
                        state_d = S_DONE;
                        beep_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Responder-facing flags follow the state being entered so they line up with state_o.
        showready_d = (state_d == S_IDLE) || (state_d == S_DONE) || (state_d == S_TIMEOUT);
        clr_n_d     = (state_d != S_ARM);
        timeout_d   = (state_d == S_TIMEOUT);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            presc_q     <= '0;
            time_q      <= BUZZ_BCD;
            winner_q    <= 4'd0;
            showready_q <= 1'b1;
            clr_n_q     <= 1'b1;
            timeout_q   <= 1'b0;
            beep_q      <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                score_q[i] <= 4'd0;
            end
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            time_q      <= time_d;
            winner_q    <= winner_d;
            showready_q <= showready_d;
            clr_n_q     <= clr_n_d;
            timeout_q   <= timeout_d;
            beep_q      <= beep_d;
            for (int i = 0; i < 4; i++) begin
                score_q[i] <= score_d[i];
            end
        end
    end

    assign resp.showready  = showready_q;
    assign resp.resp_clr_n = clr_n_q;
    assign time_bcd_o      = time_q;
    assign winner_o        = winner_q;
    assign score1_o        = score_q[0];
    assign score2_o        = score_q[1];
    assign score3_o        = score_q[2];
    assign score4_o        = score_q[3];
    assign state_o         = state_q;
    assign timeout_o       = timeout_q;
    assign beep_o          = beep_q;

endmodule
